// File: rtl/cram_port_arbiter_if.sv
// Bundle of client-side and burst-unit-side signals for the Cellular RAM port arbiter.
// The arbiter uses the slave view; whoever drives the requesters and the burst unit uses master.
interface cram_port_arbiter_if;
   // Client side: two ports packed side by side, port i in slice i
   logic [1:0]  Req;
   logic [1:0]  Write;
   logic [39:0] Addr;
   logic [7:0]  Len;
   logic [31:0] WData;
   logic [1:0]  Gnt;
   logic [1:0]  Ack;
   logic [15:0] RData;
   logic [1:0]  Done;
   logic        Err;
   logic        Ready;
   // Burst-unit side
   logic        MemCE;
   logic        MemCfg;
   logic        MemWrite;
   logic [19:0] MemAddr;
   logic [3:0]  MemLen;
   logic [15:0] MemWData;
   logic [15:0] MemRData;
   logic        MemYield;
   logic        MemFinished;

   modport slave (
      input  Req, Write, Addr, Len, WData, MemRData, MemYield, MemFinished,
      output Gnt, Ack, RData, Done, Err, Ready,
             MemCE, MemCfg, MemWrite, MemAddr, MemLen, MemWData
   );

   modport master (
      output Req, Write, Addr, Len, WData, MemRData, MemYield, MemFinished,
      input  Gnt, Ack, RData, Done, Err, Ready,
             MemCE, MemCfg, MemWrite, MemAddr, MemLen, MemWData
   );
endinterface

// File: rtl/cram_port_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of the Cellular RAM burst unit:
// configures the unit after reset, then grants, starts and watches one burst at a time.
module cram_port_arbiter #(
   parameter int TIMEOUT      = 64,
   parameter bit CFG_ON_RESET = 1'b1
) (
   input  logic                CLK,
   input  logic                RST_N,
   cram_port_arbiter_if.slave  bus,
   output logic [2:0]          dbg_state_o
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      CFG_START = 3'd0,
      CFG_WAIT  = 3'd1,
      IDLE      = 3'd2,
      START     = 3'd3,
      XFER      = 3'd4,
      RELEASE   = 3'd5
   } state_e;

   state_e          state_q;
   logic            last_q;
   logic [1:0]      gnt_q;
   logic [1:0]      ack_q;
   logic [1:0]      done_q;
   logic            err_q;
   logic            ready_q;
   logic            ce_q;
   logic            cfg_q;
   logic            wr_q;
   logic [19:0]     addr_q;
   logic [3:0]      len_q;
   logic [15:0]     rdata_q;
   logic [4:0]      cnt_q;
   logic [WD_W-1:0] wd_q;

   logic            pick;
   logic            sel_write;
   logic [19:0]     sel_addr;
   logic [3:0]      sel_len;
   logic            wd_expired;

   // On a tie the port that did not win last time goes first
   always_comb begin
      pick = bus.Req[1];
      if (bus.Req == 2'b11) begin
         pick = ~last_q;
      end
      sel_write = bus.Write[pick];
      sel_addr  = pick ? bus.Addr[39:20] : bus.Addr[19:0];
      sel_len   = pick ? bus.Len[7:4]    : bus.Len[3:0];
   end

   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= CFG_ON_RESET ? CFG_START : IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
         ack_q   <= 2'b00;
         done_q  <= 2'b00;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         ce_q    <= 1'b0;
         cfg_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         wd_q    <= '0;
      end else begin
         // Pulses default low; the watchdog restarts unless a waiting state extends it
         ce_q   <= 1'b0;
         cfg_q  <= 1'b0;
         ack_q  <= 2'b00;
         done_q <= 2'b00;
         wd_q   <= '0;
         case (state_q)
            CFG_START: begin
               ce_q    <= 1'b1;
               cfg_q   <= 1'b1;
               state_q <= CFG_WAIT;
            end
            CFG_WAIT: begin
               if (bus.MemFinished) begin
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else if (!bus.MemYield) begin
                  if (wd_expired) begin
                     err_q   <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
            end
            IDLE: begin
               if (bus.Req != 2'b00) begin
                  gnt_q   <= pick ? 2'b10 : 2'b01;
                  last_q  <= pick;
                  wr_q    <= sel_write;
                  addr_q  <= sel_addr;
                  len_q   <= sel_len;
                  cnt_q   <= (sel_len == 4'd0) ? 5'd16 : {1'b0, sel_len};
                  state_q <= START;
               end
            end
            START: begin
               ce_q    <= 1'b1;
               state_q <= XFER;
            end
            XFER: begin
               // Yields beyond the captured length are not acknowledged
               if (bus.MemYield && (cnt_q != 5'd0)) begin
                  ack_q <= gnt_q;
                  cnt_q <= cnt_q - 5'd1;
                  if (!wr_q) begin
                     rdata_q <= bus.MemRData;
                  end
               end
               if (bus.MemFinished) begin
                  done_q  <= gnt_q;
                  gnt_q   <= 2'b00;
                  state_q <= RELEASE;
               end else if (!bus.MemYield) begin
                  if (wd_expired) begin
                     err_q   <= 1'b1;
                     done_q  <= gnt_q;
                     gnt_q   <= 2'b00;
                     state_q <= RELEASE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
            end
            RELEASE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.Gnt      = gnt_q;
   assign bus.Ack      = ack_q;
   assign bus.RData    = rdata_q;
   assign bus.Done     = done_q;
   assign bus.Err      = err_q;
   assign bus.Ready    = ready_q;
   assign bus.MemCE    = ce_q;
   assign bus.MemCfg   = cfg_q;
   assign bus.MemWrite = wr_q;
   assign bus.MemAddr  = addr_q;
   assign bus.MemLen   = len_q;
   // Write data goes straight through from whichever port holds the grant
   assign bus.MemWData = gnt_q[1] ? bus.WData[31:16] : bus.WData[15:0];
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Bench for cram_port_arbiter: drives two requesters and a burst-unit model, and checks the
// arbiter's commands, word strobes and completions against a round-robin transaction model.
module tb_cram_port_arbiter;
  localparam int TIMEOUT = 64;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  cram_port_arbiter_if bus();

  cram_port_arbiter #(.TIMEOUT(TIMEOUT), .CFG_ON_RESET(1'b1)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_ce_q[$];     // {cfg, write, addr, len}
  int          exp_ce_cyc_q[$]; // required cycle of MemCE, -1 = any
  logic [17:0] exp_ack_q[$];    // {ack, rdata}
  logic [2:0]  exp_done_q[$];   // {done, err}
  int          exp_done_dly_q[$];
  logic [15:0] exp_wd_q[$];
  logic        wd_tag = 1'b0;

  // reference model: round-robin pointer, sticky error, last read word
  int          model_last = 1;
  logic        model_err = 1'b0;
  logic [15:0] model_rd = 16'h0;

  logic        t_wr[2];
  logic [19:0] t_addr[2];
  logic [3:0]  t_len[2];
  logic [15:0] t_base[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [25:0] e_ce;
    logic [17:0] e_ack;
    logic [2:0]  e_done;
    logic [15:0] e_wd;
    int          e_cyc;
    int          ce_cyc;
    logic [1:0]  prev_gnt;
    ce_cyc = 0;
    prev_gnt = 2'b00;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        prev_gnt = 2'b00;
      end else begin
        check("gnt_onehot", 32'($countones(bus.Gnt) <= 1), 32'd1);
        if (bus.Gnt != 2'b00 && bus.Gnt != prev_gnt) check("gnt_dead_cycle", 32'(prev_gnt), 32'd0);
        prev_gnt = bus.Gnt;
        if (bus.MemCE) begin
          if (exp_ce_q.size() == 0) fail("ce_unexpected", "got MemCE, expected none");
          else begin
            e_ce = exp_ce_q.pop_front();
            e_cyc = exp_ce_cyc_q.pop_front();
            check("ce_cmd", 32'({bus.MemCfg, bus.MemWrite, bus.MemAddr, bus.MemLen}), 32'(e_ce));
            if (e_cyc >= 0) check("ce_latency", 32'(cyc), 32'(e_cyc));
          end
          if (!bus.MemCfg) ce_cyc = cyc;
        end
        if (bus.Ack != 2'b00) begin
          if (exp_ack_q.size() == 0) fail("ack_unexpected", "got Ack, expected none");
          else begin
            e_ack = exp_ack_q.pop_front();
            check("ack_rdata", 32'({bus.Ack, bus.RData}), 32'(e_ack));
          end
        end
        if (wd_tag) begin
          if (exp_wd_q.size() == 0) fail("wdata_unexpected", "got write yield, expected none");
          else begin
            e_wd = exp_wd_q.pop_front();
            check("mem_wdata", 32'(bus.MemWData), 32'(e_wd));
          end
        end
        if (bus.Done != 2'b00) begin
          if (exp_done_q.size() == 0) fail("done_unexpected", "got Done, expected none");
          else begin
            e_done = exp_done_q.pop_front();
            e_cyc = exp_done_dly_q.pop_front();
            check("done_err", 32'({bus.Done, bus.Err}), 32'(e_done));
            check("done_gnt_low", 32'(bus.Gnt), 32'd0);
            if (e_cyc >= 0) check("timeout_delay", 32'(cyc - ce_cyc), 32'(e_cyc));
          end
        end
      end
    end
  end

  // Requesters present the next write word once the current one has been acknowledged
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RST_N) begin
        if (bus.Ack[0]) bus.WData[15:0] = bus.WData[15:0] + 16'd1;
        if (bus.Ack[1]) bus.WData[31:16] = bus.WData[31:16] + 16'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    repeat (2) step();
  endtask

  task automatic set_port(input int p, input logic wr, input logic [19:0] addr,
                          input logic [3:0] len, input logic [15:0] base);
    t_wr[p] = wr;
    t_addr[p] = addr;
    t_len[p] = len;
    t_base[p] = base;
    bus.Write[p] = wr;
    if (p == 0) begin
      bus.Addr[19:0] = addr;
      bus.Len[3:0] = len;
      bus.WData[15:0] = base;
    end else begin
      bus.Addr[39:20] = addr;
      bus.Len[7:4] = len;
      bus.WData[31:16] = base;
    end
  endtask

  task automatic push_ce(input int p, input int at_cyc);
    exp_ce_q.push_back({1'b0, t_wr[p], t_addr[p], t_len[p]});
    exp_ce_cyc_q.push_back(at_cyc);
  endtask

  task automatic push_done(input int p, input int dly);
    exp_done_q.push_back({2'(1 << p), model_err});
    exp_done_dly_q.push_back(dly);
  endtask

  function automatic int words(input int p);
    return (t_len[p] == 4'd0) ? 16 : int'(t_len[p]);
  endfunction

  task automatic wait_gnt(input int p);
    int n;
    n = 0;
    while (bus.Gnt[p] !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (bus.Gnt[p] !== 1'b1) fail("gnt_timeout", "got no grant, expected grant");
    bus.Req[p] = 1'b0;
  endtask

  task automatic wait_ce(output bit ok);
    int n;
    n = 0;
    while (!(bus.MemCE && !bus.MemCfg) && n < 400) begin
      step();
      n++;
    end
    ok = bus.MemCE && !bus.MemCfg;
    if (!ok) fail("ce_timeout", "got no MemCE, expected burst start");
  endtask

  // Burst-unit model for one transaction; yields are spaced so write data can advance
  task automatic serve(input int p, input int nyield, input bit together, input logic [15:0] rd_base);
    int          cnt;
    bit          ok;
    bit          fin;
    logic [15:0] d;
    cnt = words(p);
    wait_ce(ok);
    if (!ok) return;
    for (int i = 0; i < nyield; i++) begin
      repeat ($urandom_range(1, 3)) step();
      d = (rd_base != 16'h0) ? rd_base + 16'(i) : 16'($urandom);
      fin = together && (i == nyield - 1);
      bus.MemYield = 1'b1;
      bus.MemRData = d;
      bus.MemFinished = fin;
      if (i < cnt) begin
        if (t_wr[p]) begin
          exp_ack_q.push_back({2'(1 << p), model_rd});
          exp_wd_q.push_back(t_base[p] + 16'(i));
          wd_tag = 1'b1;
        end else begin
          model_rd = d;
          exp_ack_q.push_back({2'(1 << p), d});
        end
      end
      if (fin) push_done(p, -1);
      step();
      bus.MemYield = 1'b0;
      bus.MemFinished = 1'b0;
      wd_tag = 1'b0;
    end
    if (!(together && nyield > 0)) begin
      repeat ($urandom_range(1, 3)) step();
      bus.MemFinished = 1'b1;
      push_done(p, -1);
      step();
      bus.MemFinished = 1'b0;
    end
  endtask

  task automatic mem_cfg(input int dly);
    int n;
    n = 0;
    while (!(bus.MemCE && bus.MemCfg) && n < 50) begin
      step();
      n++;
    end
    if (!(bus.MemCE && bus.MemCfg)) begin
      fail("cfg_ce_timeout", "got no config pulse, expected one");
      return;
    end
    repeat (dly) begin
      step();
      check("gnt_before_ready", 32'(bus.Gnt), 32'd0);
    end
    bus.MemFinished = 1'b1;
    check("ready_low", 32'(bus.Ready), 32'd0);
    step();
    bus.MemFinished = 1'b0;
    check("ready_high", 32'(bus.Ready), 32'd1);
    check("cfg_err", 32'(bus.Err), 32'd0);
  endtask

  task automatic single(input int p, input logic wr, input logic [19:0] addr, input logic [3:0] len,
                        input logic [15:0] base, input int nyield, input bit together,
                        input logic [15:0] rd_base);
    set_port(p, wr, addr, len, base);
    push_ce(p, cyc + 2);
    model_last = p;
    bus.Req[p] = 1'b1;
    fork
      wait_gnt(p);
      serve(p, nyield, together, rd_base);
    join
    settle();
  endtask

  task automatic pair_rand();
    int first;
    int second;
    int n0;
    int n1;
    for (int p = 0; p < 2; p++)
      set_port(p, 1'($urandom_range(0, 1)), 20'($urandom), 4'($urandom), 16'($urandom));
    first = (model_last == 1) ? 0 : 1;
    second = 1 - first;
    push_ce(first, cyc + 2);
    push_ce(second, -1);
    model_last = second;
    n0 = $urandom_range(0, words(first) + 1);
    n1 = $urandom_range(0, words(second) + 1);
    bus.Req = 2'b11;
    fork
      begin
        wait_gnt(first);
        wait_gnt(second);
      end
      begin
        serve(first, n0, 1'($urandom_range(0, 1)), 16'h0);
        serve(second, n1, 1'($urandom_range(0, 1)), 16'h0);
      end
    join
    settle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n;
    int p;
    int ny;
    logic [3:0] len;
    RST_N = 1'b0;
    bus.Req = 2'b00;
    bus.Write = 2'b00;
    bus.Addr = '0;
    bus.Len = '0;
    bus.WData = '0;
    bus.MemRData = '0;
    bus.MemYield = 1'b0;
    bus.MemFinished = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_flags", 32'({bus.Gnt, bus.Ack, bus.Done, bus.Err, bus.Ready, bus.MemCE, bus.MemCfg, bus.MemWrite}), 32'd0);
    check("rst_addr_len", 32'({bus.MemAddr, bus.MemLen}), 32'd0);
    check("rst_rdata", 32'(bus.RData), 32'd0);
    exp_ce_q.push_back(26'h2000000);
    exp_ce_cyc_q.push_back(-1);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    mem_cfg(5);

    // simultaneous requests, repeated so the pointer alternates
    pair_rand();
    pair_rand();
    pair_rand();

    // directed read and a max-length write with one surplus yield
    single(0, 1'b0, 20'h12340, 4'd4, 16'h0, 4, 1'b0, 16'hA001);
    single(1, 1'b1, 20'h00777, 4'd0, 16'h0000, 17, 1'b0, 16'h0);

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 2) == 2) pair_rand();
      else begin
        p = $urandom_range(0, 1);
        len = 4'($urandom);
        ny = $urandom_range(0, ((len == 4'd0) ? 16 : int'(len)) + 1);
        single(p, 1'($urandom_range(0, 1)), 20'($urandom), len, 16'($urandom), ny,
               1'($urandom_range(0, 1)), 16'h0);
      end
    end

    // stalled burst on port 0
    set_port(0, 1'b0, 20'h0ABCD, 4'd4, 16'h0);
    push_ce(0, cyc + 2);
    model_last = 0;
    bus.Req[0] = 1'b1;
    fork
      wait_gnt(0);
      begin
        wait_ce(ok);
        model_err = 1'b1;
        if (ok) push_done(0, TIMEOUT);
      end
    join
    n = 0;
    while (exp_done_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_done_q.size() != 0) fail("timeout_done", "got no Done, expected timeout completion");
    settle();
    check("err_set", 32'(bus.Err), 32'd1);
    single(1, 1'b0, 20'h3C3C3, 4'd3, 16'h0, 3, 1'b1, 16'h0);
    check("err_sticky", 32'(bus.Err), 32'd1);

    // reset during a burst with a request pending on port 1
    set_port(0, 1'b0, 20'h55555, 4'd8, 16'h0);
    push_ce(0, cyc + 2);
    model_last = 0;
    bus.Req[0] = 1'b1;
    fork
      wait_gnt(0);
      wait_ce(ok);
    join
    repeat (3) step();
    set_port(1, 1'b1, 20'h0F0F0, 4'd3, 16'h0100);
    bus.Req[1] = 1'b1;
    RST_N = 1'b0;
    @(negedge CLK);
    check("rst_mid_flags", 32'({bus.Gnt, bus.Ack, bus.Done, bus.Err, bus.Ready, bus.MemCE, bus.MemCfg, bus.MemWrite}), 32'd0);
    check("rst_mid_addr_len", 32'({bus.MemAddr, bus.MemLen}), 32'd0);
    check("rst_mid_rdata", 32'(bus.RData), 32'd0);
    @(posedge CLK);
    #1;
    model_last = 1;
    model_err = 1'b0;
    model_rd = 16'h0;
    exp_ce_q.push_back(26'h2000000);
    exp_ce_cyc_q.push_back(-1);
    push_ce(1, -1);
    RST_N = 1'b1;
    mem_cfg(5);
    fork
      wait_gnt(1);
      serve(1, 3, 1'b0, 16'h0);
    join
    settle();

    check("ce_q_empty", 32'(exp_ce_q.size()), 32'd0);
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    check("wd_q_empty", 32'(exp_wd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
